dcache_refill_engine: RTL

Miss-service engine sitting directly downstream of the data cache in the MEM stage. When the cache reports a miss, it writes back the dirty victim line to backing main memory (optional), fetches the requested line, and streams it into the cache word by word. It models main-memory access latency with a fixed wait per line. It also exposes a debug port so the bench and loader can preload and inspect memory.

---
 rtl/refill_pkg.sv | 17 +
 rtl/main_mem_array.sv | 32 +++
 rtl/dcache_refill_engine.sv | 138 +++++++++++++
 3 files changed

// File: rtl/refill_pkg.sv
// Shared types and default sizing for the data-cache refill engine.
package refill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_WAIT,
    WB_XFER,
    RD_WAIT,
    RD_XFER,
    DONE
  } refill_state_t;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_LINE_WORDS = 8;
  localparam int DEF_LATENCY    = 4;

endpackage

// File: rtl/main_mem_array.sv
// Backing main memory: one synchronous write port shared by engine and debug,
// plus asynchronous refill and debug read ports. Contents are never reset.
module main_mem_array #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  eng_we,
  input  logic [ADDR_WIDTH-1:0] eng_addr,
  input  logic [31:0]           eng_wdata,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [31:0]           dbg_wdata,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]           rd_data,
  output logic [31:0]           dbg_rdata
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  // The engine owns the single write port whenever it writes; debug gets it otherwise.
  always_ff @(posedge clk) begin
    if (eng_we) begin
      mem[eng_addr] <= eng_wdata;
    end else if (dbg_we) begin
      mem[dbg_addr] <= dbg_wdata;
    end
  end

  assign rd_data   = mem[rd_addr];
  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: rtl/dcache_refill_engine.sv
// Miss-service engine: optional dirty-victim writeback, then line fetch streamed
// into the cache one word per cycle, each phase preceded by a fixed memory latency.
module dcache_refill_engine
  import refill_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LATENCY    = DEF_LATENCY,
  localparam int IDX_W     = $clog2(LINE_WORDS),
  localparam int LINE_AW   = ADDR_WIDTH - IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic                  wb_en,
  input  logic [LINE_AW-1:0]    wb_line_addr,
  input  logic [LINE_AW-1:0]    rd_line_addr,
  output logic [IDX_W-1:0]      wb_word_idx,
  input  logic [31:0]           wb_word,
  output logic                  refill_we,
  output logic [IDX_W-1:0]      refill_idx,
  output logic [31:0]           refill_word,
  output logic                  busy,
  output logic                  done,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [31:0]           dbg_wdata,
  output logic [31:0]           dbg_rdata
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  refill_state_t       state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [LINE_AW-1:0]  wb_line_q;
  logic [LINE_AW-1:0]  rd_line_q;
  logic [31:0]         mem_rd_data;

  // Outputs are registered alongside the state so each one is valid for exactly
  // the cycles its state occupies; the default clears them outside those states.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      wb_line_q   <= '0;
      rd_line_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      refill_we   <= 1'b0;
      refill_idx  <= '0;
      wb_word_idx <= '0;
    end else begin
      done        <= 1'b0;
      refill_we   <= 1'b0;
      refill_idx  <= '0;
      wb_word_idx <= '0;
      case (state)
        IDLE: begin
          if (miss_req) begin
            wb_line_q <= wb_line_addr;
            rd_line_q <= rd_line_addr;
            cnt       <= CNT_LOAD;
            busy      <= 1'b1;
            state     <= wb_en ? WB_WAIT : RD_WAIT;
          end
        end
        WB_WAIT: begin
          if (cnt == '0) begin
            idx   <= '0;
            state <= WB_XFER;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WB_XFER: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            cnt   <= CNT_LOAD;
            state <= RD_WAIT;
          end else begin
            idx         <= idx + 1'b1;
            wb_word_idx <= idx + 1'b1;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            idx       <= '0;
            refill_we <= 1'b1;
            state     <= RD_XFER;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_XFER: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx        <= idx + 1'b1;
            refill_we  <= 1'b1;
            refill_idx <= idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  main_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .eng_we    (state == WB_XFER),
    .eng_addr  ({wb_line_q, idx}),
    .eng_wdata (wb_word),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .rd_addr   ({rd_line_q, idx}),
    .rd_data   (mem_rd_data),
    .dbg_rdata (dbg_rdata)
  );

  assign refill_word = refill_we ? mem_rd_data : 32'h0;

endmodule
